rr_arbiter: RTL and testbench
=============================

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16, max cycles a grant may be held without done (used only with ARB_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 req  input  N_REQ  request vector, bit i = requester i.
REQ-006 done  input  1  current grant holder finished; sampled only in GRANT.
REQ-007 grant  output  N_REQ  one-hot or zero grant vector, registered.
REQ-008 state  output  3  one-hot FSM state: IDLE=001, GRANT=010, RELEASE=100.
REQ-009 busy  output  1  high exactly when state is GRANT.
REQ-010 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 FSM SHALL be one-hot, one flop per state, with the encodings of REQ-008.
REQ-012 IDLE: if req != 0, next state GRANT; grant loads the first set req bit at or after ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-013 IDLE with req == 0: remain IDLE, grant = 0.
REQ-014 Latency: grant SHALL assert on the edge after req is first sampled high in IDLE or RELEASE.
REQ-015 GRANT: grant held constant regardless of req; deassertion of the holder's req SHALL NOT release.
REQ-016 GRANT with done = 1: next state RELEASE, grant -> 0, ptr <= (granted index + 1) mod N_REQ.
REQ-017 RELEASE: grant = 0 for exactly one cycle; if req != 0, next state GRANT using the updated ptr; else IDLE.
REQ-018 done outside GRANT SHALL be ignored.
REQ-019 grant SHALL never have more than one bit set.
REQ-020 Illegal state (not exactly one bit set) SHALL return to IDLE with grant = 0 on the next edge.
REQ-021 A requester holding req continuously SHALL be granted within N_REQ grant cycles (fairness).

Reset
REQ-022 Reset SHALL take precedence over all inputs.
REQ-023 Reset values: state = 001, grant = 0, busy = 0, timeout = 0, ptr = 0, timeout counter = 0.
REQ-024 Reset asserted during GRANT SHALL drop grant on that same edge, with no timeout pulse and no ptr advance beyond reset value.

Configuration
REQ-025 Macro ARB_TIMEOUT_EN defined: counter of cycles spent in GRANT; when it reaches TIMEOUT with done = 0, force RELEASE, advance ptr per REQ-016, pulse timeout high for one cycle.
REQ-026 done and timeout condition in the same cycle: done wins, timeout SHALL NOT pulse.
REQ-027 Counter SHALL clear on every entry to GRANT.
REQ-028 Macro undefined: no counter logic; timeout port present and tied 0; a grant is held indefinitely until done.

Structure
REQ-029 Shared package rr_arbiter_pkg SHALL hold state encoding constants (ST_IDLE, ST_GRANT, ST_RELEASE) and default N_REQ/TIMEOUT constants.
REQ-030 One sub-module rr_pick: combinational round-robin selector (req, ptr -> one-hot pick, index); FSM and registers stay in rr_arbiter.
REQ-031 State flops SHALL use the team's existing dff cell with per-flop Default (IDLE flop Default=1, others 0).

Verification
REQ-032 Reset, req=0000 for 5 cycles -> state=001, grant=0000, busy=0 throughout.
REQ-033 req=0110 from IDLE, ptr=0 -> next edge grant=0010, state=010; done pulse -> RELEASE, grant=0000, then grant=0100.
REQ-034 req=1111 held, done pulsed each grant -> grant sequence 0001,0010,0100,1000,0001 with one zero cycle between each.
REQ-035 Holder drops req mid-grant, done=0 -> grant stays 0010 until done=1.
REQ-036 ARB_TIMEOUT_EN, TIMEOUT=16, done never asserted -> grant drops after 16 GRANT cycles, timeout=1 for one cycle, next requester granted; repeat with done on cycle 16 -> no timeout pulse.
REQ-037 Reset asserted while grant=1000 -> next edge grant=0000, state=001, subsequent req=1001 grants 0001.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_pkg
// Shared definitions for the round-robin arbiter slice.
// Holds the default sizing constants, the one-hot FSM state encodings and a
// helper that sizes the rotating-priority pointer.
// No ports (package).
// ---------------------------------------------------------------------------
package rr_arbiter_pkg;

   localparam int N_REQ_DEFAULT   = 4;
   localparam int TIMEOUT_DEFAULT = 16;

   localparam logic [2:0] ST_IDLE    = 3'b001;
   localparam logic [2:0] ST_GRANT   = 3'b010;
   localparam logic [2:0] ST_RELEASE = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_GRANT   = ST_GRANT,
      S_RELEASE = ST_RELEASE
   } arbState_e;

   // Pointer/index width for a given requester count, never narrower than 1.
   function automatic int ptrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter_if
// Bundles the requester-side handshake of the arbiter.
//   req     [N_REQ] request vector, bit i = requester i
//   done            current holder has finished
//   grant   [N_REQ] registered one-hot (or zero) grant
//   state   [3]     one-hot FSM state (IDLE=001, GRANT=010, RELEASE=100)
//   busy            high while in GRANT
//   timeout         one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_arbiter_if
   import rr_arbiter_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT
);

   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic [2:0]       state;
   logic             busy;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, state, busy, timeout
   );

   modport slave (
      input  req, done,
      output grant, state, busy, timeout
   );

endinterface

// File: rtl/dff.sv
// ---------------------------------------------------------------------------
// dff
// Single D flop with synchronous active-high reset to a per-instance value.
//   i_clk    clock
//   i_reset  synchronous reset, loads Default
//   i_d      data in
//   o_q      registered data out
// ---------------------------------------------------------------------------
module dff #(
   parameter logic Default = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   // Plain register; reset value chosen by the instantiating FSM.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_q <= Default;
      end else begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set request bit at or
// above the pointer, wrapping from N_REQ-1 back to 0.
//   i_req   [N_REQ] request vector
//   i_ptr   [PW]    highest-priority requester index
//   o_pick  [N_REQ] one-hot selection (zero when no request)
//   o_idx   [PW]    index of the selected requester
//   o_valid         at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PW    = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [PW-1:0]    i_ptr,
   output logic [N_REQ-1:0] o_pick,
   output logic [PW-1:0]    o_idx,
   output logic             o_valid
);

   logic [PW:0]   w_sum;
   logic [PW-1:0] w_cand;
   logic          w_found;

   // Walk the requesters in priority order starting at the pointer; the
   // extra sum bit lets the wrap be done with a single subtraction.
   always_comb begin
      o_pick  = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(N_REQ)) begin
            w_sum = w_sum - (PW+1)'(N_REQ);
         end
         w_cand = w_sum[PW-1:0];
         if (!w_found && i_req[w_cand]) begin
            w_found        = 1'b1;
            o_pick[w_cand] = 1'b1;
            o_idx          = w_cand;
         end
      end
      o_valid = w_found;
   end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a one-hot IDLE/GRANT/RELEASE FSM. A grant is held
// until the holder signals done, then the pointer moves just past the holder
// and one idle RELEASE cycle separates consecutive grants.
//   clk    clock, all state on rising edge
//   reset  synchronous active-high reset
//   bus    rr_arbiter_if.slave (req, done, grant, state, busy, timeout)
// Optional feature macro: ARB_TIMEOUT_EN -- forces a release after TIMEOUT
// GRANT cycles without done and pulses timeout; when undefined, timeout is
// tied low and a grant is held indefinitely.
// ---------------------------------------------------------------------------
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic         clk,
   input logic         reset,
   rr_arbiter_if.slave bus
);

   localparam int PW = ptrWidth(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : gBadParams
      $error("rr_arbiter: N_REQ must be 2..8 and TIMEOUT at least 1");
   end

   logic [2:0]       r_state;
   arbState_e        w_stateNext;
   logic [N_REQ-1:0] r_grant;
   logic [N_REQ-1:0] w_grantNext;
   logic [N_REQ-1:0] w_pick;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    w_ptrNext;
   logic [PW-1:0]    r_idx;
   logic [PW-1:0]    w_idxNext;
   logic [PW-1:0]    w_pickIdx;
   logic [PW-1:0]    w_idxInc;
   logic             w_pickValid;

   // One flop per state; only the IDLE flop comes out of reset set.
   dff #(.Default(1'b1)) uStIdle (
      .i_clk(clk), .i_reset(reset), .i_d(w_stateNext[0]), .o_q(r_state[0])
   );
   dff #(.Default(1'b0)) uStGrant (
      .i_clk(clk), .i_reset(reset), .i_d(w_stateNext[1]), .o_q(r_state[1])
   );
   dff #(.Default(1'b0)) uStRelease (
      .i_clk(clk), .i_reset(reset), .i_d(w_stateNext[2]), .o_q(r_state[2])
   );

   rr_pick #(.N_REQ(N_REQ), .PW(PW)) uPick (
      .i_req(bus.req), .i_ptr(r_ptr),
      .o_pick(w_pick), .o_idx(w_pickIdx), .o_valid(w_pickValid)
   );

   // Priority moves to the requester just after the one being released.
   assign w_idxInc = (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + PW'(1);

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_count;
   logic          w_expired;
   logic          w_timeoutNext;
   logic          r_timeout;

   // The counter is zero in the first GRANT cycle, so it hits TIMEOUT-1 in
   // the TIMEOUT-th cycle; leaving GRANT for any reason clears it.
   assign w_expired = (r_count == CW'(TIMEOUT - 1));
`endif

   // Next-state and next-register values; anything that is not exactly one
   // legal state bit falls into the default arm and heads back to IDLE.
   always_comb begin
      w_stateNext = S_IDLE;
      w_grantNext = '0;
      w_ptrNext   = r_ptr;
      w_idxNext   = r_idx;
`ifdef ARB_TIMEOUT_EN
      w_timeoutNext = 1'b0;
`endif
      case (r_state)
         S_IDLE, S_RELEASE: begin
            if (w_pickValid) begin
               w_stateNext = S_GRANT;
               w_grantNext = w_pick;
               w_idxNext   = w_pickIdx;
            end
         end
         S_GRANT: begin
            if (bus.done) begin
               w_stateNext = S_RELEASE;
               w_ptrNext   = w_idxInc;
            end
`ifdef ARB_TIMEOUT_EN
            else if (w_expired) begin
               w_stateNext   = S_RELEASE;
               w_ptrNext     = w_idxInc;
               w_timeoutNext = 1'b1;
            end
`endif
            else begin
               w_stateNext = S_GRANT;
               w_grantNext = r_grant;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // Grant, pointer and holder index registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant <= '0;
         r_ptr   <= '0;
         r_idx   <= '0;
      end else begin
         r_grant <= w_grantNext;
         r_ptr   <= w_ptrNext;
         r_idx   <= w_idxNext;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // GRANT-cycle counter and the registered one-cycle timeout pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_timeoutNext;
         if (r_state == S_GRANT && w_stateNext == S_GRANT) begin
            r_count <= r_count + CW'(1);
         end else begin
            r_count <= '0;
         end
      end
   end

   assign bus.timeout = r_timeout;
`else
   assign bus.timeout = 1'b0;
`endif

   assign bus.grant = r_grant;
   assign bus.state = r_state;
   assign bus.busy  = (r_state == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
// Self-checking bench for rr_arbiter (N_REQ=4, TIMEOUT=16). Directed steps
// followed by random traffic, every step checked against a behavioural model
// that tracks phase, holder, pointer and how long the grant has been held.
// Honours ARB_TIMEOUT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

   localparam int N = 4;
   localparam int T = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;

   rr_arbiter_if #(.N_REQ(N)) bus ();

   rr_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int passCount  = 0;
   int checkCount = 0;
   int failCount  = 0;

   // Model: phase 0=idle 1=grant 2=release, holder index (-1 none),
   // priority pointer, grant cycles elapsed, timeout pulse.
   int mPhase   = 0;
   int mHolder  = -1;
   int mPtr     = 0;
   int mCycles  = 0;
   bit mPulse   = 1'b0;

   // First requester at or after 'from', wrapping around the ring.
   function automatic int firstReq(input logic [N-1:0] r, input int from);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (from + k) % N;
         if (r[c[1:0]]) return c;
      end
      return -1;
   endfunction

   // Advance the model across one rising edge with the given inputs.
   task automatic modelStep(input logic [N-1:0] r, input logic d, input logic rst);
      if (rst) begin
         mPhase  = 0;
         mHolder = -1;
         mPtr    = 0;
         mCycles = 0;
         mPulse  = 1'b0;
      end else if (mPhase == 1) begin
         mCycles++;
         if (d || (TO_EN && mCycles == T)) begin
            mPulse  = !d;
            mPtr    = (mHolder + 1) % N;
            mHolder = -1;
            mPhase  = 2;
         end else begin
            mPulse = 1'b0;
         end
      end else begin
         mPulse  = 1'b0;
         mHolder = firstReq(r, mPtr);
         mPhase  = (mHolder >= 0) ? 1 : 0;
         mCycles = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [N-1:0] expGrant;
      logic [2:0]   expState;
      logic         expBusy;
      expGrant = (mHolder >= 0) ? N'(1 << mHolder) : '0;
      expState = 3'(1 << mPhase);
      expBusy  = (mPhase == 1);

      checkCount++;
      assert (bus.grant === expGrant) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s.grant observed=%b expected=%b", tag, bus.grant, expGrant);
      end
      checkCount++;
      assert (bus.state === expState) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s.state observed=%b expected=%b", tag, bus.state, expState);
      end
      checkCount++;
      assert (bus.busy === expBusy) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s.busy observed=%b expected=%b", tag, bus.busy, expBusy);
      end
      checkCount++;
      assert (bus.timeout === mPulse) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s.timeout observed=%b expected=%b", tag, bus.timeout, mPulse);
      end
   endtask

   // Drive one cycle of inputs, clock it in, then check just after the edge.
   task automatic applyStimulus(input logic [N-1:0] r, input logic d,
                                input logic rst, input string tag);
      bus.req  = r;
      bus.done = d;
      reset    = rst;
      @(posedge clk);
      modelStep(r, d, rst);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [N-1:0] rReq;
      logic         rDone;
      logic         rRst;

      bus.req  = '0;
      bus.done = 1'b0;
      $display("[TB] start, ARB_TIMEOUT_EN=%0d", TO_EN);

      repeat (2) applyStimulus(4'b0000, 1'b0, 1'b1, "reset");
      repeat (5) applyStimulus(4'b0000, 1'b0, 1'b0, "idleQuiet");

      applyStimulus(4'b0110, 1'b0, 1'b0, "firstGrant");
      applyStimulus(4'b0110, 1'b1, 1'b0, "firstRelease");
      applyStimulus(4'b0110, 1'b0, 1'b0, "secondGrant");
      applyStimulus(4'b0110, 1'b1, 1'b0, "secondRelease");
      applyStimulus(4'b0000, 1'b0, 1'b0, "backToIdle");

      applyStimulus(4'b0000, 1'b0, 1'b1, "resetRotate");
      for (int g = 0; g < 5; g++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0, "rotateGrant");
         applyStimulus(4'b1111, 1'b1, 1'b0, "rotateRelease");
      end

      applyStimulus(4'b0010, 1'b0, 1'b0, "holdGrant");
      repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0, "holdReqDropped");
      applyStimulus(4'b0000, 1'b1, 1'b0, "holdDone");
      applyStimulus(4'b0000, 1'b0, 1'b0, "holdIdle");

      applyStimulus(4'b1000, 1'b0, 1'b0, "topGrant");
      applyStimulus(4'b1000, 1'b0, 1'b1, "resetInGrant");
      applyStimulus(4'b1001, 1'b0, 1'b0, "afterReset");

      applyStimulus(4'b0000, 1'b0, 1'b1, "resetLong");
      applyStimulus(4'b0011, 1'b0, 1'b0, "longGrant");
      repeat (T) applyStimulus(4'b0011, 1'b0, 1'b0, "longNoDone");
      applyStimulus(4'b0011, 1'b0, 1'b0, "longNext");
      repeat (T - 1) applyStimulus(4'b0011, 1'b0, 1'b0, "longHold");
      applyStimulus(4'b0011, 1'b1, 1'b0, "longDoneAtLimit");
      applyStimulus(4'b0000, 1'b0, 1'b0, "longIdle");

      for (int s = 0; s < 400; s++) begin
         rReq  = N'($urandom_range(0, 15));
         rDone = ($urandom_range(0, 3) == 0);
         rRst  = ($urandom_range(0, 49) == 0);
         applyStimulus(rReq, rDone, rRst, "random");
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
